// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO unit: function codes and divider state encoding.
package hilo_pkg;

    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] MADDU = 6'b011100;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] OUT   = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift a dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] div_ext;
    logic           fits;

    always_comb begin
        trial   = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        div_ext = {1'b0, div_i};
        fits    = (trial >= div_ext);
        rem_o   = fits ? (trial - div_ext) : trial;
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider for the HI/LO unit; one quotient bit
// per clock, result {remainder, quotient} published on OUT.
module divider
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Signal,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic [2*WIDTH-1:0] dout_q, dout_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_quo;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE, DONE: begin
                if (Signal == DIVU) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = dataA;
                    div_d   = dataB;
                end else if (state_q == DONE && Signal == OUT) begin
                    dout_d = {rem_q[WIDTH-1:0], quo_q};
                end
            end
            RUN: begin
                // Commands are ignored while iterating; the counter wraps on the last step.
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
        end
    end

    assign dataOut = dout_q;
    assign busy    = busy_q;

endmodule

// File: doc/divider.md
# divider

Sequential 32-bit unsigned restoring divider for the datapath's HI/LO unit, the divide counterpart of the shift-add multiplier. It is driven by the same 6-bit `Signal` function code: `DIVU` starts a division of `dataA` by `dataB`, and `OUT` copies the finished result to `dataOut`. The result packs remainder (HI) in the upper 32 bits and quotient (LO) in the lower 32 bits. It produces one quotient bit per clock, and `busy` tells the controller when it may issue `OUT`.

## Interface
- `WIDTH`, default 32: operand width. `dataOut` is 2*WIDTH bits.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `Signal`  input  6: function code. `DIVU` = 6'b011011, `OUT` = 6'b111111; all other codes mean no operation.
- `dataA`  input  32: dividend, sampled only on the `DIVU` start edge.
- `dataB`  input  32: divisor, sampled only on the `DIVU` start edge.
- `dataOut`  output  64: {remainder, quotient}. Registered; changes only on an accepted `OUT`.
- `busy`  output  1: high while a division is iterating.

## Operation
- States:
  - IDLE: no result held.
  - RUN: iterating.
  - DONE: result held internally.
- State transitions:
  - IDLE/DONE + `DIVU`: load operands, clear the iteration counter, go to RUN.
  - RUN + counter reaching 31 on this edge: go to DONE.
  - DONE + `OUT`: dataOut <= {rem, quo}; stay in DONE. Repeated `OUT` re-drives the same value.
- Load on start: `rem` (33 bits) <= 0; `quo` <= `dataA`; `div` <= `dataB`.
- One iteration per RUN edge, restoring algorithm:
  - t = {rem[31:0], quo[31]}; quo <= quo << 1.
  - If t >= {1'b0, div}: rem <= t - div, quo[0] <= 1; else rem <= t, quo[0] <= 0.
- Exactly 32 iterations per division.
- Divide by zero needs no special path. The algorithm naturally yields quotient 32'hFFFFFFFF and remainder = `dataA`; this is the required result.
- `DIVU` during RUN is ignored. The operation in flight completes and its operands are not replaced.
- `OUT` in IDLE or RUN is ignored; `dataOut` holds its previous value.
- A new `DIVU` in DONE discards the held result. `dataOut` keeps the last value it was given until the next accepted `OUT`.
- Unsigned only. No MADD-style accumulation; HI/LO accumulate is out of scope.

## Timing
- Reset (`reset` = 0, asynchronous) forces:
  - state = IDLE, counter = 0, `busy` = 0, `dataOut` = 64'h0;
  - internal `rem`/`quo`/`div` = 0.
- Reset dominates any `Signal` value on the same edge.
- Reset asserted mid-RUN aborts the operation. After release the block is in IDLE and no result is available.
- Latency, with the start edge E0 sampling `DIVU`:
  - `busy` rises after E0.
  - Iterations occur on edges E1..E32.
  - `busy` falls after E32 and the state is DONE.
  - The earliest accepted `OUT` is at E33, and `dataOut` is valid after E33.
  - DIVU-to-result is 33 cycles.
- `busy` is a registered output, high exactly when state = RUN.
- Back-to-back operation: `DIVU` at E33 is accepted. An `OUT` on the same edge cannot also be honoured, because only one code is present per cycle.

## Structure
- Package `hilo_pkg` holds:
  - function-code constants `DIVU`, `OUT` (shared with the multiplier's `MULTU`/`MADDU`/`OUT`);
  - state encoding IDLE/RUN/DONE.
- Sub-module `div_step`: purely combinational, one restoring iteration.
  - Inputs: rem[32:0], quo[31:0], div[31:0].
  - Outputs: next rem, next quo.
- The top level holds the state register, the 5-bit counter, operand registers and the `dataOut` register.

## Test plan
- Basic division: `DIVU` with dataA=100, dataB=7; wait until `busy` = 0, then `OUT` -> dataOut = 64'h00000002_0000000E; `busy` high for exactly 32 cycles.
- Divide by zero and unit divisor:
  - 32'h12345678 / 0 -> 64'h12345678_FFFFFFFF.
  - 32'hFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF.
- Operand larger than dividend and extremes:
  - 5 / 9 -> 64'h00000005_00000000.
  - 32'hFFFFFFFF / 32'hFFFFFFFF -> 64'h00000000_00000001.
- Ignored commands:
  - `OUT` at E10 leaves `dataOut` unchanged.
  - `DIVU` with new operands at E15 is ignored; the original 100/7 result is still produced.
- Reset mid-operation: assert `reset` = 0 at E20 between edges -> `busy` = 0 and `dataOut` = 0 immediately. A subsequent `OUT` changes nothing; a fresh `DIVU` 81/9 then gives 64'h00000000_00000009.
